// File: rtl/mem_responder.sv
// Fixed-latency memory responder for a control-store requester: 32-bit word/byte storage.
// Optional misaligned-word check is compiled in with `define MEM_ALIGN_CHECK_EN (adds port err).
module mem_responder #(
  parameter int LATENCY     = 3,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        err,
`endif
  output logic [1:0]  o_dbg_state
);

  // Handshake: the requester raises cs and holds it (with stable we/size/addr/wdata
  // until acceptance) until mem_ready; cs is only sampled in IDLE, and mem_ready is a
  // single-cycle pulse LATENCY cycles after the accepting edge.

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_we;
  logic          w_size;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_old;
  logic [31:0]   w_wr_word;
  logic [31:0]   w_rd_word;
  logic          w_go;
  logic          w_misalign;
  logic          w_unused;

  // With LATENCY=1 the access completes on its accepting edge, so live inputs are used then.
  always_comb begin
    w_we    = r_we;
    w_size  = r_size;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    if (r_state == IDLE) begin
      w_we    = we;
      w_size  = size;
      w_addr  = addr;
      w_wdata = wdata;
    end
  end

  assign w_idx    = w_addr[AW+1:2];
  assign w_old    = r_mem[w_idx];
  assign w_unused = ^w_addr[31:AW+2];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_size && (w_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_wr_word = w_old;
    w_rd_word = {24'b0, w_old[{w_addr[1:0], 3'b000} +: 8]};
    if (w_size) begin
      w_wr_word = w_wdata;
      w_rd_word = w_old;
    end else begin
      w_wr_word[{w_addr[1:0], 3'b000} +: 8] = w_wdata[7:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cs) w_next = (LATENCY == 1) ? READY : BUSY;
      BUSY:    if (r_cnt <= 4'd1) w_next = READY;
      READY:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_go = (w_next == READY) && (r_state != READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (cs) begin
            r_cnt   <= 4'(LATENCY - 1);
            r_we    <= we;
            r_size  <= size;
            r_addr  <= addr;
            r_wdata <= wdata;
          end
        end
        BUSY:    r_cnt <= r_cnt - 4'd1;
        default: ;
      endcase
      if (w_go && w_misalign) r_rdata <= 32'd0;
      else if (w_go && !w_we) r_rdata <= w_rd_word;
    end
  end

  // Storage is deliberately not reset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && w_go && w_we && !w_misalign) r_mem[w_idx] <= w_wr_word;
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_go && w_misalign;
  end
  assign err = r_err;
`endif

  assign rdata       = r_rdata;
  assign mem_ready   = (r_state == READY);
  assign o_dbg_state = r_state;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide parameter LATENCY, default 3: cycles from request acceptance to mem_ready (legal 1..15).
REQ-002 SHALL provide parameter DEPTH_WORDS, default 1024: 32-bit words of storage (power of two).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port cs  input  1  request strobe from the control store; held high by the requester until mem_ready.
REQ-006 SHALL provide port we  input  1  1 = write, 0 = read.
REQ-007 SHALL provide port size  input  1  1 = word, 0 = byte.
REQ-008 SHALL provide port addr  input  32  byte address.
REQ-009 SHALL provide port wdata  input  32  write data; byte writes use wdata[7:0].
REQ-010 SHALL provide port rdata  output  32  registered read data.
REQ-011 SHALL provide port mem_ready  output  1  registered completion pulse.
REQ-012 SHALL provide port err  output  1  registered misaligned-access flag; present only per REQ-027.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, READY; mem_ready SHALL equal (state == READY).
REQ-014 IDLE with cs=1 at an edge SHALL latch we, size, addr, wdata and load the counter with LATENCY-1; go to BUSY, or directly to READY if LATENCY=1.
REQ-015 BUSY SHALL decrement the counter each edge; at counter 1 it SHALL go to READY.
REQ-016 mem_ready SHALL first be high in the LATENCY-th cycle after the accepting edge, for exactly one cycle.
REQ-017 READY SHALL always return to IDLE at the next edge; back-to-back requests therefore have one IDLE cycle between mem_ready pulses.
REQ-018 cs, we, size, addr and wdata SHALL be ignored in BUSY and READY; requests use latched values only.
REQ-019 Writes SHALL commit at the edge entering READY: word writes replace the word; byte writes replace lane addr[1:0] only.
REQ-020 Reads SHALL load rdata at the edge entering READY: word read returns the full word; byte read returns lane addr[1:0] zero-extended.
REQ-021 rdata SHALL hold its value until the next read completes; writes SHALL leave rdata unchanged.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so accesses wrap.
REQ-023 A read and write to the same word in consecutive requests SHALL return the newly written data.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, counter 0, mem_ready 0, rdata 0, err 0.
REQ-025 rst during BUSY SHALL discard the pending access; no memory write SHALL occur. Storage contents are not cleared.
REQ-026 rst SHALL take priority over cs at the same edge.

Configuration
REQ-027 With macro MEM_ALIGN_CHECK_EN defined, a word access with addr[1:0] != 0 SHALL complete with normal latency, SHALL NOT write memory, SHALL load rdata 0, and SHALL drive err=1 only during its READY cycle. Otherwise err SHALL be 0.
REQ-028 Without MEM_ALIGN_CHECK_EN, port err SHALL be absent and word accesses SHALL ignore addr[1:0].

Verification
REQ-029 LATENCY=3: rst, then write word 0x12345678 at 0x10 (cs held) -> mem_ready high exactly in the 3rd cycle after acceptance, for one cycle.
REQ-030 Byte write 0xAB to 0x11, then word read at 0x10 -> rdata 0x1234AB78; byte read at 0x11 -> rdata 0x000000AB.
REQ-031 cs held high across two reads (0x10, then 0x14) -> two mem_ready pulses separated by one IDLE cycle; rdata updates only at each READY entry.
REQ-032 Write 0xDEADBEEF at 0x10, rst asserted in the 2nd BUSY cycle, then read 0x10 -> rdata 0x1234AB78; mem_ready never pulses for the aborted write.
REQ-033 DEPTH_WORDS=1024, write 0xCAFEF00D at 0x1000, read 0x0 -> rdata 0xCAFEF00D (wrap).
REQ-034 MEM_ALIGN_CHECK_EN defined: word write at 0x12 -> err=1 with mem_ready, memory unchanged; following word read at 0x10 -> err=0.
